lc3_eab_sequencer: RTL and testbench
====================================

Name: lc3_eab_sequencer

Overview:
- Multi-cycle controller that decodes an LC-3 instruction and sequences the effective-address block (EAB) plus the MAR/memory handshake for all address-forming instructions.
- Drives the ADDR1MUX select (selEAB1) and ADDR2MUX select (selEAB2), then issues the load strobes and memory accesses the instruction needs.
- Sits between the instruction register and the EAB/MAR/MDR datapath. The top-level FSM hands it one instruction at a time.

Parameters:
- TIMEOUT_CYCLES, 16, maximum wait for mem_ready before abort (used only with the optional feature).
- CNT_W, 5, width of the timeout counter. It must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to execute ir_in; accepted only in IDLE
- ir_in  in  16  instruction word, captured on accept
- nzp_match  in  1  condition codes match IR[11:9]; sampled in ADDR
- mem_ready  in  1  memory access complete this cycle
- selEAB1  out  1  ADDR1MUX select: 1 = Ra, 0 = PC
- selEAB2  out  2  ADDR2MUX select: 3 = off11, 2 = off9, 1 = off6, 0 = zero
- ld_mar  out  1  MAR <= eabOut
- ld_mar_mdr  out  1  MAR <= MDR (indirect pointer)
- ld_pc  out  1  PC <= eabOut
- ld_reg  out  1  DR <= eabOut (LEA)
- mem_en  out  1  memory access request
- mem_we  out  1  write when 1
- ld_mdr  out  1  MDR <= memory data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: illegal opcode or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, IR latch=0. All outputs are 0, including selEAB1=0 and selEAB2=0.
- Select decode from latched IR[15:12], held stable from ADDR through DONE:
  - BR 0000: PC, off9
  - LD 0010 / ST 0011 / LDI 1010 / STI 1011 / LEA 1110: PC, off9
  - JSR 0100 with IR[11]=1: PC, off11
  - JSRR 0100 with IR[11]=0: Ra, zero
  - LDR 0110 / STR 0111: Ra, off6
  - JMP 1100: Ra, zero
  - All other opcodes are illegal.
- States: IDLE, ADDR, RD1, RD2, WR, DONE.
- IDLE: start=1 latches ir_in and moves to ADDR next cycle. start is ignored while busy.
- ADDR (1 cycle), by instruction class:
  - BR: ld_pc=nzp_match, then DONE.
  - JMP/JSR/JSRR: ld_pc=1, then DONE.
  - LEA: ld_reg=1, then DONE.
  - LD/LDR/LDI/STI: ld_mar=1, then RD1.
  - ST/STR: ld_mar=1, then WR.
  - Illegal: err=1, return to IDLE; no done pulse.
- RD1:
  - mem_en=1, mem_we=0 until mem_ready.
  - On mem_ready: ld_mdr=1.
  - Next state: LDI goes to RD2 with ld_mar_mdr asserted in the first RD2 cycle. STI goes to WR with ld_mar_mdr asserted in the first WR cycle (no memory request that cycle). Others go to DONE.
- RD2: mem_en=1 until mem_ready; ld_mdr=1 on ready; then DONE.
- WR: mem_en=1, mem_we=1 until mem_ready; then DONE.
- DONE: done=1 for one cycle, then IDLE. A start in the DONE cycle is ignored; a new start is accepted only from IDLE.
- mem_en deasserts in the cycle after mem_ready. mem_ready seen outside a memory state is ignored.
- Latency with zero-wait memory (start to done):
  - BR/JMP/JSR/LEA: 3 cycles
  - LD/LDR/ST/STR: 4 cycles
  - LDI: 6 cycles
  - STI: 6 cycles
- Reset mid-operation aborts immediately to IDLE. No partial strobes follow.

Optional Feature:
- Macro LC3_MEM_TIMEOUT_EN.
- Defined: a counter clears on entry to each of RD1/RD2/WR and increments each cycle mem_ready=0. When it reaches TIMEOUT_CYCLES, err pulses for one cycle, mem_en drops, state returns to IDLE, and no done pulse is issued.
- Undefined: no counter; memory states wait indefinitely.

Decomposition:
- Shared package lc3_pkg: opcode localparams (OP_BR, OP_LD, ...), ADDR1/ADDR2 select encodings (SEL1_PC, SEL1_RA, SEL2_ZERO, SEL2_OFF6, SEL2_OFF9, SEL2_OFF11), state encoding.
- One natural sub-module, lc3_eab_decode: combinational IR to {selEAB1, selEAB2, class, illegal}. It is reusable by the top-level controller.

Test Plan:
- LD, ir_in=16'h2205, zero-wait memory -> selEAB1=0, selEAB2=2; ld_mar in cycle 2; mem_en, mem_we=0 in cycle 3; done in cycle 4.
- LDI, ir_in=16'hA003, mem_ready delayed 2 cycles on each access -> two read phases; ld_mar_mdr exactly once; done 10 cycles after start.
- STR, ir_in=16'h7283 -> selEAB1=1, selEAB2=1 throughout; mem_we=1 during WR; ld_mdr never asserted.
- BR, ir_in=16'h0E10 with nzp_match=0 then 1 -> ld_pc=0 then 1; done after 3 cycles in both runs.
- Illegal opcode 16'hD000 -> err pulse in cycle 2, no done, busy low in cycle 3. Separately: rst_n low during RD1 -> all outputs 0 asynchronously.
- With LC3_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=16, hold mem_ready=0 on ST -> err after 16 WR cycles; mem_en low afterwards; no done pulse.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the EAB sequencer: opcodes, ADDR1/ADDR2 mux
// encodings, controller states and the address-forming instruction classes.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    localparam logic       SEL1_PC    = 1'b0;
    localparam logic       SEL1_RA    = 1'b1;
    localparam logic [1:0] SEL2_ZERO  = 2'd0;
    localparam logic [1:0] SEL2_OFF6  = 2'd1;
    localparam logic [1:0] SEL2_OFF9  = 2'd2;
    localparam logic [1:0] SEL2_OFF11 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD1,
        ST_RD2,
        ST_WR,
        ST_DONE
    } state_t;

    // JUMP covers JMP, JSR and JSRR; LOAD covers LD/LDR; STORE covers ST/STR.
    typedef enum logic [2:0] {
        CLS_BR,
        CLS_JUMP,
        CLS_LEA,
        CLS_LOAD,
        CLS_LDI,
        CLS_STORE,
        CLS_STI,
        CLS_ILLEGAL
    } eab_class_t;

endpackage

// File: rtl/lc3_eab_decode.sv
// Combinational decode of the IR opcode (plus the JSR/JSRR bit) into the
// ADDR1MUX/ADDR2MUX selects and the sequencing class of the instruction.
module lc3_eab_decode
    import lc3_pkg::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_jsr_long,
    output logic       o_sel1,
    output logic [1:0] o_sel2,
    output eab_class_t o_class,
    output logic       o_illegal
);

    always_comb begin
        o_sel1  = SEL1_PC;
        o_sel2  = SEL2_ZERO;
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_BR:  begin o_sel2 = SEL2_OFF9; o_class = CLS_BR;    end
            OP_LD:  begin o_sel2 = SEL2_OFF9; o_class = CLS_LOAD;  end
            OP_ST:  begin o_sel2 = SEL2_OFF9; o_class = CLS_STORE; end
            OP_LDI: begin o_sel2 = SEL2_OFF9; o_class = CLS_LDI;   end
            OP_STI: begin o_sel2 = SEL2_OFF9; o_class = CLS_STI;   end
            OP_LEA: begin o_sel2 = SEL2_OFF9; o_class = CLS_LEA;   end
            OP_JSR: begin
                o_class = CLS_JUMP;
                if (i_jsr_long) begin
                    o_sel2 = SEL2_OFF11;
                end else begin
                    o_sel1 = SEL1_RA;
                end
            end
            OP_LDR: begin o_sel1 = SEL1_RA; o_sel2 = SEL2_OFF6; o_class = CLS_LOAD;  end
            OP_STR: begin o_sel1 = SEL1_RA; o_sel2 = SEL2_OFF6; o_class = CLS_STORE; end
            OP_JMP: begin o_sel1 = SEL1_RA; o_class = CLS_JUMP; end
            default: ;
        endcase
    end

    assign o_illegal = (o_class == CLS_ILLEGAL);

endmodule

// File: rtl/lc3_eab_sequencer.sv
// Multi-cycle EAB / MAR / memory-handshake sequencer for LC-3 address-forming
// instructions. Define LC3_MEM_TIMEOUT_EN to abort memory waits after TIMEOUT_CYCLES.
module lc3_eab_sequencer
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir_in,
    input  logic        nzp_match,
    input  logic        mem_ready,
    output logic        selEAB1,
    output logic [1:0]  selEAB2,
    output logic        ld_mar,
    output logic        ld_mar_mdr,
    output logic        ld_pc,
    output logic        ld_reg,
    output logic        mem_en,
    output logic        mem_we,
    output logic        ld_mdr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_t      r_state;
    logic [15:0] r_ir;
    logic        r_ptr;      // first RD2/WR cycle of LDI/STI: MAR <= MDR, no access
    logic        w_sel1;
    logic [1:0]  w_sel2;
    eab_class_t  w_class;
    logic        w_illegal;
    logic        w_busy;
    logic        w_timeout;
    logic        w_unused_ir_bits;

    lc3_eab_decode u_decode (
        .i_opcode   (r_ir[15:12]),
        .i_jsr_long (r_ir[11]),
        .o_sel1     (w_sel1),
        .o_sel2     (w_sel2),
        .o_class    (w_class),
        .o_illegal  (w_illegal)
    );

    assign w_unused_ir_bits = ^{r_ir[10:0], w_illegal};

    if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cnt_w_too_narrow_for_timeout
    end

`ifdef LC3_MEM_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Only cycles actually waiting on memory count; pointer cycles restart the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_ptr || !(r_state == ST_RD1 || r_state == ST_RD2 || r_state == ST_WR)) begin
            r_cnt <= '0;
        end else if (!mem_ready && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_ptr   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_ir    <= ir_in;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_ptr <= 1'b0;
                    case (w_class)
                        CLS_LOAD, CLS_LDI, CLS_STI: r_state <= ST_RD1;
                        CLS_STORE:                  r_state <= ST_WR;
                        CLS_ILLEGAL:                r_state <= ST_IDLE;
                        default:                    r_state <= ST_DONE;
                    endcase
                end
                ST_RD1: begin
                    if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (mem_ready) begin
                        if (w_class == CLS_LDI) begin
                            r_state <= ST_RD2;
                            r_ptr   <= 1'b1;
                        end else if (w_class == CLS_STI) begin
                            r_state <= ST_WR;
                            r_ptr   <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_RD2, ST_WR: begin
                    if (r_ptr) begin
                        r_ptr <= 1'b0;
                    end else if (w_timeout) begin
                        r_state <= ST_IDLE;
                    end else if (mem_ready) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_busy = (r_state != ST_IDLE);

    // Strobes decode from registered state/IR; ld_pc (BR) and ld_mdr follow
    // their same-cycle qualifiers so zero-wait memory costs no extra cycle.
    always_comb begin
        selEAB1    = w_busy ? w_sel1 : SEL1_PC;
        selEAB2    = w_busy ? w_sel2 : SEL2_ZERO;
        ld_mar     = 1'b0;
        ld_mar_mdr = 1'b0;
        ld_pc      = 1'b0;
        ld_reg     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        ld_mdr     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        busy       = w_busy;
        case (r_state)
            ST_ADDR: begin
                case (w_class)
                    CLS_BR:      ld_pc  = nzp_match;
                    CLS_JUMP:    ld_pc  = 1'b1;
                    CLS_LEA:     ld_reg = 1'b1;
                    CLS_ILLEGAL: err    = 1'b1;
                    default:     ld_mar = 1'b1;
                endcase
            end
            ST_RD1: begin
                if (w_timeout) begin
                    err = 1'b1;
                end else begin
                    mem_en = 1'b1;
                    ld_mdr = mem_ready;
                end
            end
            ST_RD2: begin
                if (r_ptr) begin
                    ld_mar_mdr = 1'b1;
                end else if (w_timeout) begin
                    err = 1'b1;
                end else begin
                    mem_en = 1'b1;
                    ld_mdr = mem_ready;
                end
            end
            ST_WR: begin
                if (r_ptr) begin
                    ld_mar_mdr = 1'b1;
                end else if (w_timeout) begin
                    err = 1'b1;
                end else begin
                    mem_en = 1'b1;
                    mem_we = 1'b1;
                end
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_eab_sequencer.sv
// Scoreboard bench for lc3_eab_sequencer: random instructions and memory
// latencies, expected per-instruction summaries from a table-driven model.
module tb_lc3_eab_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] ir_in;
    logic        nzp_match;
    logic        mem_ready;
    logic        selEAB1;
    logic [1:0]  selEAB2;
    logic        ld_mar, ld_mar_mdr, ld_pc, ld_reg;
    logic        mem_en, mem_we, ld_mdr;
    logic        busy, done, err;

    lc3_eab_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir_in      (ir_in),
        .nzp_match  (nzp_match),
        .mem_ready  (mem_ready),
        .selEAB1    (selEAB1),
        .selEAB2    (selEAB2),
        .ld_mar     (ld_mar),
        .ld_mar_mdr (ld_mar_mdr),
        .ld_pc      (ld_pc),
        .ld_reg     (ld_reg),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .ld_mdr     (ld_mdr),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       sel1;
        bit [1:0] sel2;
        bit       is_err;
        int       lat;
        int       n_mar, n_mdrmar, n_pc, n_reg, n_mdr, n_we;
    } exp_t;

    exp_t exp_q[$];
    int   delay_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   mon_en   = 1'b0;
    int   idle_noise = 0;
    int   txn_idx  = 0;

    wire [12:0] all_outs = {selEAB1, selEAB2, ld_mar, ld_mar_mdr, ld_pc, ld_reg,
                            mem_en, mem_we, ld_mdr, busy, done, err};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Reference: what one instruction must produce, from the opcode table and
    // the memory delays (extra wait cycles per access) the responder will apply.
    function automatic exp_t model(input logic [15:0] ir, input bit nzp, input int d0, input int d1);
        exp_t e;
        e = '{sel1: 0, sel2: 0, is_err: 0, lat: 0, n_mar: 0, n_mdrmar: 0,
              n_pc: 0, n_reg: 0, n_mdr: 0, n_we: 0};
        case (ir[15:12])
            4'h0: begin e.sel2 = 2; e.lat = 3; e.n_pc = nzp; end
            4'h2: begin e.sel2 = 2; e.lat = 4 + d0; e.n_mar = 1; e.n_mdr = 1; end
            4'h3: begin e.sel2 = 2; e.lat = 4 + d0; e.n_mar = 1; e.n_we = d0 + 1; end
            4'h4: begin
                if (ir[11]) e.sel2 = 3; else e.sel1 = 1;
                e.lat = 3; e.n_pc = 1;
            end
            4'h6: begin e.sel1 = 1; e.sel2 = 1; e.lat = 4 + d0; e.n_mar = 1; e.n_mdr = 1; end
            4'h7: begin e.sel1 = 1; e.sel2 = 1; e.lat = 4 + d0; e.n_mar = 1; e.n_we = d0 + 1; end
            4'hA: begin e.sel2 = 2; e.lat = 6 + d0 + d1; e.n_mar = 1; e.n_mdrmar = 1; e.n_mdr = 2; end
            4'hB: begin
                e.sel2 = 2; e.lat = 6 + d0 + d1; e.n_mar = 1; e.n_mdrmar = 1;
                e.n_mdr = 1; e.n_we = d1 + 1;
            end
            4'hC: begin e.sel1 = 1; e.lat = 3; e.n_pc = 1; end
            4'hE: begin e.sel2 = 2; e.lat = 3; e.n_reg = 1; end
            default: begin e.is_err = 1; e.lat = 2; end
        endcase
        return e;
    endfunction

    function automatic int n_access(input logic [3:0] op);
        case (op)
            4'h2, 4'h3, 4'h6, 4'h7: return 1;
            4'hA, 4'hB:             return 2;
            default:                return 0;
        endcase
    endfunction

    // Memory responder: ready after the queued number of wait cycles; random
    // ready noise whenever no access is requested (must be ignored).
    initial begin
        int cur;
        cur = -1;
        mem_ready = 1'b0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!rst_n) begin
                cur = -1;
            end else if (mem_en) begin
                if (cur < 0) cur = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                if (cur == 0) begin
                    mem_ready = 1'b1;
                    cur = -1;
                end else begin
                    cur--;
                end
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Monitor: summarises each busy interval and scores it on done/err.
    initial begin
        bit   in_txn;
        int   t0, c_mar, c_mdrmar, c_pc, c_reg, c_mdr, c_we;
        bit   s1;
        bit [1:0] s2;
        bit   sel_chg;
        exp_t e;
        in_txn = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (mon_en) begin
                if (busy) begin
                    if (!in_txn) begin
                        in_txn = 1; t0 = cyc; s1 = selEAB1; s2 = selEAB2; sel_chg = 0;
                        c_mar = 0; c_mdrmar = 0; c_pc = 0; c_reg = 0; c_mdr = 0; c_we = 0;
                    end
                    c_mar += int'(ld_mar);   c_mdrmar += int'(ld_mar_mdr);
                    c_pc  += int'(ld_pc);    c_reg    += int'(ld_reg);
                    c_mdr += int'(ld_mdr);   c_we     += int'(mem_we);
                    if (selEAB1 != s1 || selEAB2 != s2) sel_chg = 1;
                end else if (all_outs != 13'd0) begin
                    idle_noise++;
                end
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("t%0d_err", txn_idx), int'(err), int'(e.is_err));
                        check($sformatf("t%0d_done", txn_idx), int'(done), int'(!e.is_err));
                        check($sformatf("t%0d_latency", txn_idx), cyc - t0 + 2, e.lat);
                        if (!e.is_err) begin
                            check($sformatf("t%0d_selEAB1", txn_idx), int'(s1), int'(e.sel1));
                            check($sformatf("t%0d_selEAB2", txn_idx), int'(s2), int'(e.sel2));
                            check($sformatf("t%0d_sel_stable", txn_idx), int'(sel_chg), 0);
                        end
                        check($sformatf("t%0d_ld_mar", txn_idx), c_mar, e.n_mar);
                        check($sformatf("t%0d_ld_mar_mdr", txn_idx), c_mdrmar, e.n_mdrmar);
                        check($sformatf("t%0d_ld_pc", txn_idx), c_pc, e.n_pc);
                        check($sformatf("t%0d_ld_reg", txn_idx), c_reg, e.n_reg);
                        check($sformatf("t%0d_ld_mdr", txn_idx), c_mdr, e.n_mdr);
                        check($sformatf("t%0d_mem_we_cycles", txn_idx), c_we, e.n_we);
                        $display("txn %0d ir=%h term=%s latency=%0d", txn_idx, dut.r_ir,
                                 err ? "err" : "done", cyc - t0 + 2);
                    end
                    txn_idx++;
                    in_txn = 0;
                end
            end
        end
    end

    task automatic finish_now(input string why);
        $display("FAIL %s: got timeout, required progress", why);
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "bench aborted");
    endtask

    // Waits for IDLE (spurious starts while busy must be ignored), then issues.
    task automatic run_txn(input logic [15:0] ir, input bit nzp, input int d0, input int d1);
        int w;
        w = 0;
        @(negedge clk);
        while (busy) begin
            if (w > 300) finish_now("wait_idle");
            start = $urandom_range(0, 1);
            ir_in = 16'($urandom);
            @(negedge clk);
            w++;
        end
        start = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        exp_q.push_back(model(ir, nzp, d0, d1));
        if (n_access(ir[15:12]) >= 1) delay_q.push_back(d0);
        if (n_access(ir[15:12]) == 2) delay_q.push_back(d1);
        start = 1'b1;
        ir_in = ir;
        nzp_match = nzp;
        @(negedge clk);
        start = 1'b0;
    endtask

    localparam int ND = 6;
    logic [15:0] dir_ir  [ND] = '{16'h2205, 16'hA003, 16'h7283, 16'h0E10, 16'h0E10, 16'hD000};
    bit          dir_nzp [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int          dir_d0  [ND] = '{0, 2, 1, 0, 0, 0};
    int          dir_d1  [ND] = '{0, 2, 0, 0, 0, 0};

    initial begin
        int w;
        rst_n = 1'b0; start = 1'b0; ir_in = 16'h0; nzp_match = 1'b0;
        #2;
        check("reset_outputs", int'(all_outs), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        #1;
        check("idle_after_reset_outputs", int'(all_outs), 0);

        for (int i = 0; i < ND; i++) run_txn(dir_ir[i], dir_nzp[i], dir_d0[i], dir_d1[i]);
        for (int i = 0; i < 80; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            run_txn(r, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        w = 0;
        while (exp_q.size() > 0 && w < 300) begin @(negedge clk); w++; end
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_output_noise", idle_noise, 0);

        // Abort an LD in RD1 with reset: outputs must clear without a clock edge.
        @(negedge clk);
        mon_en = 1'b0;
        delay_q.delete();
        delay_q.push_back(20);
        start = 1'b1; ir_in = 16'h2205; nzp_match = 1'b0;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!mem_en && w < 10) begin @(negedge clk); w++; end
        check("reached_rd1_before_reset", int'(mem_en), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(all_outs), 0);
        @(negedge clk);
        check("reset_held_outputs", int'(all_outs), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_idle_outputs", int'(all_outs), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
